// File: rtl/daq_pkg.sv
// Shared types and constants for the LPDAQ capture sequencer.
package daq_pkg;

  localparam int unsigned DEF_AXIS_DW = 24;
  localparam int unsigned DEF_CNT_W   = 32;

  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_EXT = 2'd1;
  localparam logic [1:0] TRIG_THR = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    FLUSH,
    DRAIN
  } state_t;

endpackage

// File: rtl/daq_capture_seq_if.sv
// AXI-Stream style sample port between the capture sequencer and the FIFO interface.
interface daq_capture_seq_if
  import daq_pkg::*;
#(
  parameter int unsigned DW = DEF_AXIS_DW
);

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/daq_trig_detect.sv
// Trigger decision for the capture sequencer: immediate, external edge or threshold crossing.
module daq_trig_detect
  import daq_pkg::*;
#(
  parameter int unsigned DW = DEF_AXIS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    trig_mode,
  input  logic [DW-1:0] thresh,
  input  logic          trig_in,
  input  logic [DW-1:0] adc_tdata,
  input  logic          adc_tvalid,
  output logic          trig_c
);

  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  logic          trig_q;
  logic [DW-1:0] prev_q;

  // History registers; prev_q starts at the most negative value so the first sample above threshold fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= 1'b0;
      prev_q <= MOST_NEG;
    end else begin
      trig_q <= trig_in;
      if (adc_tvalid) begin
        prev_q <= adc_tdata;
      end
    end
  end

  always_comb begin
    trig_c = 1'b0;
    case (trig_mode)
      TRIG_IMM: trig_c = adc_tvalid;
      TRIG_EXT: trig_c = adc_tvalid && trig_in && !trig_q;
      TRIG_THR: trig_c = adc_tvalid
                         && ($signed(adc_tdata) > $signed(thresh))
                         && ($signed(prev_q) <= $signed(thresh));
      default:  trig_c = adc_tvalid;
    endcase
  end

endmodule

// File: rtl/daq_capture_seq.sv
// Capture sequencer: arms on command, waits for a trigger, forwards cfg_len samples and tracks host drain.
module daq_capture_seq
  import daq_pkg::*;
#(
  parameter int unsigned AXIS_DW = DEF_AXIS_DW,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic [1:0]         cfg_trig_mode,
  input  logic [AXIS_DW-1:0] cfg_thresh,
  input  logic               trig_in,
  input  logic [AXIS_DW-1:0] adc_tdata,
  input  logic               adc_tvalid,
  daq_capture_seq_if.master  m_axis,
  input  logic [CNT_W-1:0]   rd_cnt,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   cap_cnt,
  output logic               irq
);

  state_t state_q, state_d;

  logic [AXIS_DW-1:0] data_q;
  logic               vld_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   rd_base_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   cap_q;
  logic [CNT_W-1:0]   drop_q;
  logic               abort_q;
  logic               busy_q;
  logic               done_q;
  logic               aborted_q;
  logic               overflow_q;
  logic               irq_q;

  logic trig_c;
  logic arm_c;
  logic take_c;
  logic load_c;
  logic drop_c;
  logic accept_c;
  logic last_c;
  logic drained_c;
  logic set_done_c;
  logic set_abort_c;
  logic flag_abort_c;

  daq_trig_detect #(
    .DW (AXIS_DW)
  ) u_trig (
    .clk        (clk),
    .rst        (rst),
    .trig_mode  (cfg_trig_mode),
    .thresh     (cfg_thresh),
    .trig_in    (trig_in),
    .adc_tdata  (adc_tdata),
    .adc_tvalid (adc_tvalid),
    .trig_c     (trig_c)
  );

  assign accept_c  = vld_q && m_axis.tready;
  assign load_c    = take_c && (!vld_q || m_axis.tready);
  assign drop_c    = take_c && !load_c;
  assign last_c    = (issued_q + CNT_W'(1)) == len_q;
  // Modular difference keeps the drain check correct across rd_cnt wrap.
  assign drained_c = (rd_cnt - rd_base_q) >= cap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control; samples are taken in ARMED on trigger and in CAPTURE on every strobe.
  always_comb begin
    state_d      = state_q;
    arm_c        = 1'b0;
    take_c       = 1'b0;
    set_done_c   = 1'b0;
    set_abort_c  = 1'b0;
    flag_abort_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start && (cfg_len != '0)) begin
          arm_c   = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (cfg_abort) begin
          set_abort_c = 1'b1;
          state_d     = IDLE;
        end else if (trig_c) begin
          take_c  = 1'b1;
          state_d = last_c ? FLUSH : CAPTURE;
        end
      end
      CAPTURE: begin
        take_c = adc_tvalid;
        if (cfg_abort) begin
          flag_abort_c = 1'b1;
          state_d      = FLUSH;
        end else if (adc_tvalid && last_c) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!vld_q) begin
          if (abort_q) begin
            set_abort_c = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cfg_abort) begin
          set_abort_c = 1'b1;
          state_d     = IDLE;
        end else if (drained_c) begin
          set_done_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-entry output register; a load with a simultaneous accept keeps it full with the new sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (load_c) begin
      data_q <= adc_tdata;
      vld_q  <= 1'b1;
    end else if (accept_c) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      rd_base_q  <= '0;
      issued_q   <= '0;
      cap_q      <= '0;
      drop_q     <= '0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      irq_q  <= set_done_c || set_abort_c;
      if (arm_c) begin
        len_q      <= cfg_len;
        rd_base_q  <= rd_cnt;
        issued_q   <= '0;
        cap_q      <= '0;
        drop_q     <= '0;
        abort_q    <= 1'b0;
        done_q     <= 1'b0;
        aborted_q  <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (take_c) begin
          issued_q <= issued_q + CNT_W'(1);
        end
        if (drop_c) begin
          drop_q     <= drop_q + CNT_W'(1);
          overflow_q <= 1'b1;
        end
        if (accept_c) begin
          cap_q <= cap_q + CNT_W'(1);
        end
        if (flag_abort_c) begin
          abort_q <= 1'b1;
        end
        if (set_done_c) begin
          done_q <= 1'b1;
        end
        if (set_abort_c) begin
          aborted_q <= 1'b1;
        end
      end
    end
  end

  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = vld_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_q;
  assign cap_cnt       = cap_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_daq_capture_seq.sv
// Self-checking bench for daq_capture_seq with a scoreboard on the output stream.
module tb_daq_capture_seq;
  import daq_pkg::*;

  localparam int unsigned DW = 24;
  localparam int unsigned CW = 32;

  logic          clk;
  logic          rst;
  logic          cfg_start;
  logic          cfg_abort;
  logic [CW-1:0] cfg_len;
  logic [1:0]    cfg_trig_mode;
  logic [DW-1:0] cfg_thresh;
  logic          trig_in;
  logic [DW-1:0] adc_tdata;
  logic          adc_tvalid;
  logic [CW-1:0] rd_cnt;
  logic          busy, done, aborted, overflow, irq;
  logic [CW-1:0] drop_cnt, cap_cnt;

  daq_capture_seq_if #(.DW(DW)) m_axis ();

  daq_capture_seq #(.AXIS_DW(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_len       (cfg_len),
    .cfg_trig_mode (cfg_trig_mode),
    .cfg_thresh    (cfg_thresh),
    .trig_in       (trig_in),
    .adc_tdata     (adc_tdata),
    .adc_tvalid    (adc_tvalid),
    .m_axis        (m_axis),
    .rd_cnt        (rd_cnt),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .cap_cnt       (cap_cnt),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int irq_seen = 0;
  logic [DW-1:0] exp_q[$];
  bit hold_pend = 0;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] want;

  // Stream monitor: scoreboard pops on each handshake, and a stalled beat must hold.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 0;
    end else begin
      if (irq === 1'b1) irq_seen++;
      if (hold_pend) begin
        total++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== hold_data) begin
          bad++;
          $display("FAIL axis_hold got valid=%b data=%0d want valid=1 data=%0d",
                   m_axis.tvalid, m_axis.tdata, hold_data);
        end
      end
      if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL axis_extra got data=%0d want no beat", m_axis.tdata);
        end else begin
          want = exp_q.pop_front();
          if (m_axis.tdata !== want) begin
            bad++;
            $display("FAIL axis_data got=%0d want=%0d", m_axis.tdata, want);
          end
        end
      end
      hold_pend = (m_axis.tvalid === 1'b1) && (m_axis.tready !== 1'b1);
      hold_data = m_axis.tdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm(input logic [1:0] mode, input logic [CW-1:0] len);
    cfg_trig_mode = mode;
    cfg_len       = len;
    cfg_start     = 1'b1;
    step();
    cfg_start     = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v);
    adc_tdata  = v;
    adc_tvalid = 1'b1;
    step();
    adc_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 0; cfg_abort = 0; cfg_len = '0; cfg_trig_mode = TRIG_IMM;
    cfg_thresh = '0; trig_in = 0; adc_tdata = '0; adc_tvalid = 0; rd_cnt = 32'd10;
    m_axis.tready = 1'b1;
    step(3);
    total++;
    if ({busy, done, aborted, overflow, irq, m_axis.tvalid, drop_cnt, cap_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_in got busy=%b done=%b abt=%b ovf=%b irq=%b vld=%b drop=%0d cap=%0d want all 0",
               busy, done, aborted, overflow, irq, m_axis.tvalid, drop_cnt, cap_cnt);
    end
    rst = 1'b0;
    step(2);
    total++;
    if ({busy, done, aborted, overflow, irq, m_axis.tvalid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_out got busy=%b done=%b abt=%b want 0", busy, done, aborted);
    end
  endtask

  task automatic test_arm_abort();
    int irq0;
    arm(TRIG_IMM, '0);
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_start got busy=%b want 0", busy);
    end
    arm(TRIG_IMM, 32'd3);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL armed_busy got=%b want 1", busy);
    end
    irq0 = irq_seen;
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    step(2);
    total++;
    if ({busy, aborted, done} !== 3'b010 || irq_seen - irq0 != 1) begin
      bad++;
      $display("FAIL armed_abort got busy=%b abt=%b done=%b irqs=%0d want 0 1 0 1",
               busy, aborted, done, irq_seen - irq0);
    end
  endtask

  task automatic test_immediate();
    int irq0;
    m_axis.tready = 1'b1;
    rd_cnt = 32'd10;
    arm(TRIG_IMM, 32'd4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    for (int i = 1; i <= 6; i++) send(DW'(i));
    step(2);
    total++;
    if (cap_cnt !== 32'd4 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL imm_pre_drain got cap=%0d busy=%b done=%b want 4 1 0", cap_cnt, busy, done);
    end
    total++;
    if (overflow !== 1'b0 || drop_cnt !== 32'd0) begin
      bad++;
      $display("FAIL imm_no_overflow got ovf=%b drop=%0d want 0 0", overflow, drop_cnt);
    end
    irq0 = irq_seen;
    rd_cnt = 32'd14;
    wait_idle("imm");
    step(2);
    total++;
    if (done !== 1'b1 || aborted !== 1'b0 || irq_seen - irq0 != 1) begin
      bad++;
      $display("FAIL imm_done got done=%b abt=%b irqs=%0d want 1 0 1", done, aborted, irq_seen - irq0);
    end
  endtask

  task automatic test_threshold();
    cfg_thresh = DW'(100);
    arm(TRIG_THR, 32'd2);
    exp_q.push_back(DW'(150));
    exp_q.push_back(DW'(90));
    send(DW'(50)); send(DW'(150)); send(DW'(90)); send(DW'(120)); send(DW'(130));
    step(3);
    total++;
    if (cap_cnt !== 32'd2) begin
      bad++;
      $display("FAIL thr_cap got=%0d want=2", cap_cnt);
    end
    rd_cnt = rd_cnt + 32'd2;
    wait_idle("thr");
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL thr_done got=%b want=1", done);
    end
  endtask

  task automatic test_backpressure();
    m_axis.tready = 1'b0;
    arm(TRIG_IMM, 32'd5);
    exp_q.push_back(DW'(11));
    for (int i = 11; i <= 15; i++) send(DW'(i));
    step();
    total++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== DW'(11)) begin
      bad++;
      $display("FAIL bp_hold got vld=%b data=%0d want 1 11", m_axis.tvalid, m_axis.tdata);
    end
    total++;
    if (drop_cnt !== 32'd4 || overflow !== 1'b1 || cap_cnt !== 32'd0) begin
      bad++;
      $display("FAIL bp_drop got drop=%0d ovf=%b cap=%0d want 4 1 0", drop_cnt, overflow, cap_cnt);
    end
    m_axis.tready = 1'b1;
    step(3);
    total++;
    if (cap_cnt !== 32'd1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got cap=%0d busy=%b done=%b want 1 1 0", cap_cnt, busy, done);
    end
    rd_cnt = rd_cnt + 32'd1;
    wait_idle("bp");
    total++;
    if (done !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_done got done=%b ovf=%b want 1 1", done, overflow);
    end
  endtask

  task automatic test_ext_trig();
    m_axis.tready = 1'b1;
    trig_in = 1'b1;
    step(2);
    arm(TRIG_EXT, 32'd2);
    send(DW'(21)); send(DW'(22));
    trig_in = 1'b0;
    send(DW'(23));
    total++;
    if (cap_cnt !== 32'd0 || m_axis.tvalid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ext_no_trig got cap=%0d vld=%b busy=%b want 0 0 1", cap_cnt, m_axis.tvalid, busy);
    end
    trig_in = 1'b1;
    exp_q.push_back(DW'(24));
    exp_q.push_back(DW'(25));
    send(DW'(24)); send(DW'(25));
    step(3);
    total++;
    if (cap_cnt !== 32'd2) begin
      bad++;
      $display("FAIL ext_cap got=%0d want=2", cap_cnt);
    end
    rd_cnt = rd_cnt + 32'd2;
    wait_idle("ext");
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL ext_done got=%b want=1", done);
    end
    trig_in = 1'b0;
  endtask

  task automatic test_abort_capture();
    int irq0;
    m_axis.tready = 1'b0;
    arm(TRIG_IMM, 32'd8);
    exp_q.push_back(DW'(31));
    send(DW'(31)); send(DW'(32));
    irq0 = irq_seen;
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    step(3);
    total++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== DW'(31) || busy !== 1'b1 || aborted !== 1'b0) begin
      bad++;
      $display("FAIL abt_pending got vld=%b data=%0d busy=%b abt=%b want 1 31 1 0",
               m_axis.tvalid, m_axis.tdata, busy, aborted);
    end
    m_axis.tready = 1'b1;
    wait_idle("abt");
    step(2);
    total++;
    if (aborted !== 1'b1 || done !== 1'b0 || cap_cnt !== 32'd1 || irq_seen - irq0 != 1) begin
      bad++;
      $display("FAIL abt_final got abt=%b done=%b cap=%0d irqs=%0d want 1 0 1 1",
               aborted, done, cap_cnt, irq_seen - irq0);
    end
  endtask

  task automatic test_drain_wrap();
    logic [CW-1:0] rds[3];
    int irq0;
    rds[0] = 32'hFFFF_FFFF; rds[1] = 32'h0; rds[2] = 32'h1;
    m_axis.tready = 1'b1;
    rd_cnt = 32'hFFFF_FFFE;
    arm(TRIG_IMM, 32'd4);
    for (int i = 41; i <= 44; i++) exp_q.push_back(DW'(i));
    for (int i = 41; i <= 44; i++) send(DW'(i));
    step(3);
    irq0 = irq_seen;
    for (int i = 0; i < 3; i++) begin
      rd_cnt = rds[i];
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL wrap_early rd=%0h got done=%b busy=%b want 0 1", rds[i], done, busy);
      end
    end
    rd_cnt = 32'h2;
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_done got done=%b busy=%b want 1 0", done, busy);
    end
    step(2);
    total++;
    if (irq_seen - irq0 != 1) begin
      bad++;
      $display("FAIL wrap_irq got=%0d want=1", irq_seen - irq0);
    end
  endtask

  initial begin
    test_reset();
    test_arm_abort();
    test_immediate();
    test_threshold();
    test_backpressure();
    test_ext_trig();
    test_abort_capture();
    test_drain_wrap();
    step(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
